// File: rtl/dmem_resp_pkg.sv
// Shared types and RV32I load/store size codes for the data-memory responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_valid(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables/data shift and load extract/extend.
// Invalid size codes fall back to a full-word access.
module dmem_lane_align
    import dmem_resp_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata
);

    logic       is_b;
    logic       is_h;
    logic       sgn;
    logic [1:0] sh;
    logic [31:0] rsh;

    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        sgn  = 1'b0;
        if (f3_valid(we, funct3)) begin
            case (funct3)
                F3_B:    begin is_b = 1'b1; sgn = 1'b1; end
                F3_BU:   is_b = 1'b1;
                F3_H:    begin is_h = 1'b1; sgn = 1'b1; end
                F3_HU:   is_h = 1'b1;
                default: ;
            endcase
        end
    end

    // Halfwords ignore addr[0], words ignore addr[1:0]
    always_comb begin
        sh = 2'b00;
        be = 4'b1111;
        if (is_b) begin
            sh = lane;
            be = 4'b0001 << lane;
        end else if (is_h) begin
            sh = {lane[1], 1'b0};
            be = 4'b0011 << {lane[1], 1'b0};
        end
        wdata_sh = wdata << {sh, 3'b000};
        rsh      = rword >> {sh, 3'b000};
    end

    always_comb begin
        rdata = rword;
        if (is_b) begin
            rdata = {{24{sgn & rsh[7]}}, rsh[7:0]};
        end else if (is_h) begin
            rdata = {{16{sgn & rsh[15]}}, rsh[15:0]};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder with byte-lane stores and extended loads.
// Define DMEM_RESPONDER_ERR_EN for misalign/range/funct3 fault reporting.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        exec;
    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [2:0]  op_f3;
    logic [29:0] widx;
    logic [AW-1:0] idx;
    logic        fault;
    logic        wr_en;
    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic [31:0] rword;
    logic [31:0] rdata_ext;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req_valid && (state_q == ST_IDLE);

    // Zero-wait requests execute straight from the request inputs
    always_comb begin
        exec = 1'b0;
        if (state_q == ST_IDLE) begin
            exec = accept && (WAIT_L == 4'd0);
        end else if (state_q == ST_BUSY) begin
            exec = (cnt_q <= 4'd1);
        end
        op_we    = (state_q == ST_IDLE) ? req_we     : we_q;
        op_addr  = (state_q == ST_IDLE) ? req_addr   : addr_q;
        op_wdata = (state_q == ST_IDLE) ? req_wdata  : wdata_q;
        op_f3    = (state_q == ST_IDLE) ? req_funct3 : f3_q;
        widx     = op_addr[31:2];
    end

`ifdef DMEM_RESPONDER_ERR_EN
    logic in_range;
    logic misalign;

    always_comb begin
        in_range = ({2'b00, widx} < 32'(DEPTH_WORDS));
        misalign = (((op_f3 == F3_H) || (op_f3 == F3_HU)) && op_addr[0])
                || ((op_f3 == F3_W) && (op_addr[1:0] != 2'b00));
        fault    = !in_range || misalign || !f3_valid(op_we, op_f3);
        idx      = widx[AW-1:0];
    end
`else
    always_comb begin
        fault = 1'b0;
        idx   = AW'({2'b00, widx} % 32'(DEPTH_WORDS));
    end
`endif

    dmem_lane_align u_align (
        .we       (op_we),
        .funct3   (op_f3),
        .lane     (op_addr[1:0]),
        .wdata    (op_wdata),
        .rword    (rword),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (rdata_ext)
    );

    assign rword = mem[idx];
    assign wr_en = exec && op_we && !fault && !rst;

    // Storage is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (WAIT_L == 4'd0) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (exec) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d   = WAIT_L;
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            f3_d    = req_funct3;
        end else if (state_q == ST_BUSY) begin
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end
        if (exec) begin
            rdata_d = (op_we || fault) ? 32'd0 : rdata_ext;
            err_d   = fault;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WAIT_CYCLES=2 instance plus a zero-wait one.
// Fault expectations follow DMEM_RESPONDER_ERR_EN when it is defined.
module tb_dmem_responder;
    import dmem_resp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [2:0]  z_req_funct3;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic xact(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int lat;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready @%h: got %b want 1", addr, req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL latency @%h: got %0d want 3", addr, lat);
        end
        e = sb.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL rdata @%h f3=%0d: got %h want %h", addr, f3, rsp_rdata, e.rdata);
        end
        checks++;
        if (rsp_err !== e.err) begin
            errors++;
            $display("FAIL err @%h f3=%0d: got %b want %b", addr, f3, rsp_err, e.err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL return_idle @%h: got valid=%b ready=%b want 0/1",
                     addr, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        rsp_ready = 0;
        z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0;
        z_req_funct3 = 0; z_rsp_ready = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rd=%h want 1/0/0/0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        xact(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'd0, 1'b0);
        xact(1'b0, 32'h10, 32'd0, F3_W, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_lanes();
        xact(1'b1, 32'h11, 32'h0000007F, F3_B, 32'd0, 1'b0);
        xact(1'b0, 32'h11, 32'd0, F3_B,  32'h0000007F, 1'b0);
        xact(1'b0, 32'h13, 32'd0, F3_B,  32'hFFFFFFDE, 1'b0);
        xact(1'b0, 32'h13, 32'd0, F3_BU, 32'h000000DE, 1'b0);
        xact(1'b0, 32'h12, 32'd0, F3_H,  32'hFFFFDEAD, 1'b0);
        xact(1'b0, 32'h12, 32'd0, F3_HU, 32'h0000DEAD, 1'b0);
        xact(1'b0, 32'h10, 32'd0, F3_W,  32'hDEAD7FEF, 1'b0);
        xact(1'b1, 32'h14, 32'hFFFF8001, F3_H, 32'd0, 1'b0);
        xact(1'b0, 32'h14, 32'd0, F3_H,  32'hFFFF8001, 1'b0);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W;
        sb.push_back('{rdata: 32'hDEAD7FEF, err: 1'b0});
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
            req_wdata = 32'h0; req_funct3 = F3_W;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== e.rdata) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b rd=%h want 1/0/%h",
                         i, rsp_valid, req_ready, rsp_rdata, e.rdata);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got vld=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
        xact(1'b0, 32'h10, 32'd0, F3_W, 32'hDEAD7FEF, 1'b0);
    endtask

    task automatic test_faults();
        xact(1'b1, 32'h0, 32'h12345678, F3_W, 32'd0, 1'b0);
`ifdef DMEM_RESPONDER_ERR_EN
        xact(1'b1, 32'h12, 32'h1, F3_W, 32'd0, 1'b1);
        xact(1'b0, 32'h10, 32'd0, F3_W, 32'hDEAD7FEF, 1'b0);
        xact(1'b0, 32'h1000, 32'd0, F3_W, 32'd0, 1'b1);
        xact(1'b0, 32'h11, 32'd0, F3_H, 32'd0, 1'b1);
        xact(1'b0, 32'h10, 32'd0, 3'b011, 32'd0, 1'b1);
`else
        xact(1'b0, 32'h1000, 32'd0, F3_W, 32'h12345678, 1'b0);
        xact(1'b0, 32'h11, 32'd0, F3_H, 32'h00007FEF, 1'b0);
        xact(1'b0, 32'h13, 32'd0, F3_W, 32'hDEAD7FEF, 1'b0);
        xact(1'b0, 32'h10, 32'd0, 3'b011, 32'hDEAD7FEF, 1'b0);
`endif
    endtask

    task automatic test_reset_busy();
        xact(1'b1, 32'h20, 32'h11111111, F3_W, 32'd0, 1'b0);
        xact(1'b0, 32'h10, 32'd0, F3_W, 32'hDEAD7FEF, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h5; req_funct3 = F3_W;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b vld=%b err=%b rd=%h want 1/0/0/0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h20, 32'd0, F3_W, 32'h11111111, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic        we_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad_t [4] = '{32'h44, 32'h44, 32'h48, 32'h48};
        logic [31:0] wd_t [4] = '{32'hCAFEF00D, 32'h0, 32'h0BADC0DE, 32'h0};
        logic [31:0] ex_t [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0BADC0DE};
        int pres[$];
        exp_t e;
        int cyc = 0, idx = 0, got = 0, last = -1, p;
        z_rsp_ready = 1'b1;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (z_rsp_valid === 1'b1) begin
                e = sb.pop_front();
                p = pres.pop_front();
                checks++;
                if (z_rsp_rdata !== e.rdata || z_rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b",
                             got, z_rsp_rdata, z_rsp_err, e.rdata, e.err);
                end
                checks++;
                if (cyc - p != 1) begin
                    errors++;
                    $display("FAIL b2b_latency[%0d]: got %0d want 1", got, cyc - p);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: got %0d want 2", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            if (z_req_ready === 1'b1 && idx < 4) begin
                z_req_valid  = 1'b1;
                z_req_we     = we_t[idx];
                z_req_addr   = ad_t[idx];
                z_req_wdata  = wd_t[idx];
                z_req_funct3 = F3_W;
                sb.push_back('{rdata: ex_t[idx], err: 1'b0});
                pres.push_back(cyc);
                idx++;
            end
        end
        z_req_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 4", got);
        end
        @(negedge clk);
        z_rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_backpressure();
        test_faults();
        test_reset_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between request accept and response (0..15).
REQ-003 SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  async active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  block accepts a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_funct3  in  3  RV32I size/sign code
- rsp_valid  out  1  response available
- rsp_ready  in  1  core accepts the response
- rsp_rdata  out  32  load data, extended; 0 for stores
- rsp_err  out  1  access fault

Function
REQ-005 SHALL implement FSM IDLE, BUSY, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-006 IDLE: on req_valid&req_ready, SHALL capture we/addr/wdata/funct3 and load wait counter with WAIT_CYCLES; next state BUSY, or RESP when WAIT_CYCLES=0.
REQ-007 BUSY: counter SHALL decrement each cycle; on the cycle it reaches 1 the access executes and the next state is RESP; latency from accept edge to rsp_valid = WAIT_CYCLES+1 cycles.
REQ-008 Stores SHALL commit at the BUSY->RESP (or IDLE->RESP) edge, writing only the addressed byte lanes; other bytes unchanged.
REQ-009 Loads: funct3 000 LB, 001 LH, 100 LBU, 101 LHU SHALL sign-extend or zero-extend the addressed lane; 010 LW returns the word.
REQ-010 Stores: funct3 000 SB, 001 SH, 010 SW; any other store funct3 and load funct3 011/110/111 are invalid.
REQ-011 RESP: rsp_rdata/rsp_err SHALL hold stable until rsp_valid&rsp_ready, then go to IDLE; no new request is accepted in the same cycle.
REQ-012 Word index SHALL be req_addr[31:2]; byte lane req_addr[1:0].
REQ-013 Request inputs SHALL be ignored outside the IDLE accept cycle.

Reset
REQ-014 rst SHALL force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, asynchronously.
REQ-015 Reset during BUSY SHALL discard the pending store; storage array SHALL not be cleared by reset.

Configuration
REQ-016 Macro DMEM_RESPONDER_ERR_EN defined: rsp_err=1 for misaligned access (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0), word index >= DEPTH_WORDS, or invalid funct3; faulting stores SHALL not write; faulting loads return rsp_rdata=0.
REQ-017 Macro not defined: rsp_err tied 0; word index taken modulo DEPTH_WORDS; halfword ignores addr[0], word ignores addr[1:0]; invalid funct3 treated as word access.

Structure
REQ-018 Package dmem_resp_pkg SHALL hold the FSM state enum and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-019 Combinational sub-module dmem_lane_align SHALL produce store byte-enables/shifted data and load extract/extend from funct3 and addr[1:0].

Verification
REQ-020 Reset, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid exactly 3 cycles after accept (WAIT_CYCLES=2).
REQ-021 After REQ-020, SB 0x11 data 0x7F, then LB 0x11 -> 0x0000007F; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
REQ-022 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; release -> IDLE next cycle.
REQ-023 With DMEM_RESPONDER_ERR_EN: SW 0x12 data 0x1 -> rsp_err=1, subsequent LW 0x10 unchanged; LW 0x1000 (DEPTH 1024) -> rsp_err=1, rdata 0; without macro: LW 0x1000 returns word at 0x0.
REQ-024 Assert rst mid-BUSY of SW 0x20 data 0x5 -> outputs at reset values immediately; later LW 0x20 returns prior contents.
REQ-025 WAIT_CYCLES=0: LW accepted -> rsp_valid next cycle; back-to-back requests with rsp_ready=1 -> one transaction per 2 cycles.
